// File: rtl/mmu_ctrl_if.sv
// CU-side request/response bundle for mmu_ctrl: valid/ready request channel
// plus a single-cycle response pulse.
interface mmu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mmu_ctrl.sv
// Memory-management controller between CU and on-chip SRAM: sized accesses,
// lane steering, alignment/range errors. MMU_ACCESS_CNT_EN adds access counters.
module mmu_ctrl #(
  parameter  int DEPTH_WORDS = 128,
  parameter  int SRAM_LAT    = 1,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          soc_clk,
  input  logic          soc_rst_n,
  mmu_ctrl_if.slave     bus,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_be,
  output logic [31:0]   sram_wdata,
  output logic          sram_rd,
  output logic          sram_wr,
  input  logic [31:0]   sram_rdata,
  output logic [15:0]   acc_rd_cnt,
  output logic [15:0]   acc_wr_cnt,
  output logic [15:0]   acc_err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          err_q, err_d;
  logic [2:0]    lat_q, lat_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   steer_wdata;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  // Request is rejected at accept time so a bad access never reaches the SRAM.
  always_comb begin
    acc_err = 1'b0;
    case (bus.req_size)
      2'b01:   acc_err = bus.req_addr[0];
      2'b10:   acc_err = |bus.req_addr[1:0];
      2'b11:   acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS)) acc_err = 1'b1;
  end

  always_comb begin
    case (size_q)
      2'b00:   begin be = 4'b0001 << off_q; steer_wdata = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = 4'b0011 << off_q; steer_wdata = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;          steer_wdata = wdata_q;            end
    endcase
  end

  // Word accesses are aligned, so off_q is 0 and the shift is a pass-through.
  assign shifted = sram_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    err_d   = err_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          off_d   = bus.req_addr[1:0];
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          waddr_d = bus.req_addr[AW+1:2];
          err_d   = acc_err;
          rdata_d = 32'h0;
          state_d = acc_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        lat_d   = 3'(SRAM_LAT - 1);
        state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == 3'd0) begin
          rdata_d = load_data;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge soc_rst_n) begin
    if (!soc_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      waddr_q <= '0;
      err_q   <= 1'b0;
      lat_q   <= 3'd0;
      rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state, so an async reset drops them at once.
  assign sram_rd    = (state_q == S_ACCESS) && !we_q;
  assign sram_wr    = (state_q == S_ACCESS) &&  we_q;
  assign sram_addr  = (state_q == S_ACCESS) ? waddr_q     : '0;
  assign sram_be    = (state_q == S_ACCESS) ? be          : 4'h0;
  assign sram_wdata = (state_q == S_ACCESS) ? steer_wdata : 32'h0;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;

`ifdef MMU_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == S_RESP) begin
      if (err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge soc_clk or negedge soc_rst_n) begin
    if (!soc_rst_n) begin
      rd_cnt_q  <= 16'h0;
      wr_cnt_q  <= 16'h0;
      err_cnt_q <= 16'h0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign acc_rd_cnt  = rd_cnt_q;
  assign acc_wr_cnt  = wr_cnt_q;
  assign acc_err_cnt = err_cnt_q;
`else
  assign acc_rd_cnt  = 16'h0;
  assign acc_wr_cnt  = 16'h0;
  assign acc_err_cnt = 16'h0;
`endif

endmodule

// File: doc/mmu_ctrl.md
Name: mmu_ctrl

Overview:
- Parametrised memory-management controller placed between the CU and the on-chip SRAM, replacing the single-pulse stub.
- Adds a valid/ready request handshake and byte/half/word access sizing with lane steering and sign/zero extension.
- Adds alignment and range checking with an error response.
- Supports SRAM read latency configurable by parameter; one outstanding request at a time.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit SRAM words; SRAM word address width AW = $clog2(DEPTH_WORDS).
- SRAM_LAT, 1, cycles from the sram_rd pulse to valid sram_rdata (legal range 1..7).

Ports:
- soc_clk  input  1  system clock, all logic on rising edge.
- soc_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CU request valid.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_we  input  1  0 = load, 1 = store.
- req_addr  input  32  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result (0 for stores and errors).
- rsp_err  output  1  qualified by rsp_valid; misaligned, out-of-range or reserved size.
- sram_addr  output  AW  SRAM word address (req_addr[AW+1:2]).
- sram_be  output  4  SRAM byte enables.
- sram_wdata  output  32  lane-steered store data.
- sram_rd  output  1  one-cycle read strobe.
- sram_wr  output  1  one-cycle write strobe.
- sram_rdata  input  32  SRAM read data.
- acc_rd_cnt  output  16  load counter (see Optional Feature).
- acc_wr_cnt  output  16  store counter.
- acc_err_cnt  output  16  error counter.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0 except req_ready = 1; FSM state is IDLE.
- Reset asserted mid-operation aborts the access. No rsp_valid is issued for the aborted request, and sram_rd/sram_wr drop immediately.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Accept when req_valid && req_ready; latch all request fields.
  - Error check at accept:
    - req_size = 11 is an error.
    - Half with addr[0] != 0 is an error.
    - Word with addr[1:0] != 0 is an error.
    - addr[31:2] >= DEPTH_WORDS is an error.
  - On error, go to RESP with err = 1.
  - Otherwise, go to ACCESS.
- ACCESS (1 cycle):
  - Drive sram_addr, sram_be and sram_wdata, and pulse sram_rd or sram_wr for exactly this cycle.
  - Store: go to RESP.
  - Load: go to WAIT, with the latency counter loaded with SRAM_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture sram_rdata and go to RESP.
  - With SRAM_LAT = 1, WAIT lasts 1 cycle.
- RESP (1 cycle):
  - rsp_valid = 1, with rsp_err and rsp_rdata registered, then return to IDLE.
  - req_ready rises in the cycle after RESP.
- Latency, counted from the accept edge to the rsp_valid cycle:
  - Store: 2 cycles.
  - Load: 2 + SRAM_LAT cycles.
  - Error: 1 cycle.
- Byte-enable generation (o = addr[1:0]):
  - Byte: be = 4'b0001 << o.
  - Half: be = 4'b0011 << o.
  - Word: be = 4'b1111.
- Store data steering:
  - Byte: byte replicated ×4.
  - Half: halfword replicated ×2.
  - Word: as-is.
- Load extraction:
  - Byte: sram_rdata[8o+7:8o].
  - Half: sram_rdata[8o+15:8o].
  - Result is extended to 32 bits per req_unsigned; word loads ignore req_unsigned.
- Request signals are ignored while req_ready = 0. Holding req_valid high across RESP has it accepted in the following IDLE cycle.
- sram_rd and sram_wr are never asserted together, and never asserted on an errored request.
- Highest valid word address (DEPTH_WORDS-1) is accepted; DEPTH_WORDS errors.

Optional Feature:
- Macro: MMU_ACCESS_CNT_EN.
- Defined:
  - acc_rd_cnt, acc_wr_cnt and acc_err_cnt are 16-bit saturating counters (hold at 16'hFFFF).
  - Each counter increments in the RESP cycle of a successful load, a successful store, or any error respectively.
  - All counters clear on reset.
- Not defined: all three outputs are tied to 16'h0 and no counter flops are synthesised.

Test Plan:
- Word store then load:
  - Stimulus: store addr 0x10, wdata 0xDEADBEEF, size 10; then load addr 0x10.
  - Required: sram_wr with be 1111 and sram_addr 4; rsp_rdata 0xDEADBEEF; load rsp_valid 3 cycles after accept (SRAM_LAT = 1).
- Byte store and loads:
  - Stimulus: byte store 0x80 to addr 0x13; then signed byte load addr 0x13; then unsigned byte load addr 0x13.
  - Required: store be 1000 and sram_wdata 0x80808080; loads return 0xFFFFFF80 then 0x00000080.
- Halfword access:
  - Stimulus: half store 0x1234 at addr 0x22; then half load addr 0x22.
  - Required: store be 1100; load returns 0x00001234.
- Error cases:
  - Stimulus: word load addr 0x02; half store addr 0x05; word load addr DEPTH_WORDS*4; size 11.
  - Required: each gives rsp_valid 1 cycle after accept with rsp_err = 1 and rsp_rdata = 0, and no sram_rd/sram_wr pulse.
- Latency and reset:
  - Stimulus: SRAM_LAT = 3 load; soc_rst_n pulsed low during WAIT.
  - Required: no rsp_valid for the aborted load; req_ready = 1 during reset; next load completes at 5 cycles.
- MMU_ACCESS_CNT_EN:
  - Stimulus: 3 loads, 2 stores, 1 error.
  - Required: counters read 3/2/1; without the macro all read 0.
